// File: rtl/fetch_unit_if.sv
// fetch_unit_if: imem request/response, redirect and decode handshake bundle for the fetch front end
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvld;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misalign;
  logic        if_vld;
  logic [31:0] if_pc;
  logic [31:0] if_insn;
  logic        id_ready;
  modport master (
    output imem_req, imem_addr, misalign, if_vld, if_pc, if_insn,
    input  imem_gnt, imem_rvld, imem_rdata, redirect, redirect_pc, id_ready
  );
  modport slave (
    input  imem_req, imem_addr, misalign, if_vld, if_pc, if_insn,
    output imem_gnt, imem_rvld, imem_rdata, redirect, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with a small {pc, insn} buffer and redirect flush
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master f
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_FULL, S_DRAIN} state_t;
  state_t      state, state_nx;
  logic [31:0] pc, req_pc;
  logic [31:0] buf_pc   [BUF_DEPTH];
  logic [31:0] buf_insn [BUF_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt, cnt_nx;
  logic redir, push, pop, misalign;
  assign redir  = f.redirect && state != S_IDLE;
  assign push   = state == S_WAIT && f.imem_rvld && !redir;
  assign pop    = f.if_vld && f.id_ready && !redir;
  assign cnt_nx = redir ? '0 : cnt + CW'(push) - CW'(pop);
  assign f.imem_req  = state == S_REQ;
  assign f.imem_addr = pc;
  assign f.misalign  = misalign;
  assign f.if_vld    = cnt != '0;
  assign f.if_pc     = buf_pc[rd_ptr];
  assign f.if_insn   = buf_insn[rd_ptr];
  // a request granted in the redirect cycle is stale, so its response must be drained
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = S_REQ;
      S_REQ:   state_nx = f.imem_gnt ? (redir ? S_DRAIN : S_WAIT) : S_REQ;
      S_WAIT:  state_nx = redir ? (f.imem_rvld ? S_REQ : S_DRAIN)
                        : !f.imem_rvld ? S_WAIT
                        : cnt_nx == CW'(BUF_DEPTH) ? S_FULL : S_REQ;
      S_FULL:  state_nx = (redir || pop) ? S_REQ : S_FULL;
      S_DRAIN: state_nx = f.imem_rvld ? S_REQ : S_DRAIN;
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      req_pc   <= '0;
      misalign <= 1'b0;
      cnt      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_pc[i]   <= '0;
        buf_insn[i] <= '0;
      end
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      misalign <= redir && f.redirect_pc[1:0] != 2'b00;
      if (redir) begin
        pc     <= f.redirect_pc & ~32'h3;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (state == S_REQ && f.imem_gnt) begin
          req_pc <= pc;
          pc     <= pc + 32'd4;
        end
        if (push) begin
          buf_pc[wr_ptr]   <= req_pc;
          buf_insn[wr_ptr] <= f.imem_rdata;
          wr_ptr           <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed fetch, backpressure, redirect, misalign and reset scenarios
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic auto_mem = 1'b0;
  logic [31:0] g_addr = '0;
  int n_cmp = 0;
  int n_err = 0;
  int guard;
  fetch_unit_if f();
  fetch_unit #(.RESET_PC(32'h0), .BUF_DEPTH(2)) dut (.clk(clk), .rst_n(rst_n), .f(f.master));
  always #5 clk = ~clk;
  function automatic logic [31:0] insn_of(input logic [31:0] a);
    return a == 32'h0 ? 32'h0050_0093 : {16'h1300, a[15:0]};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // zero-wait memory: grant whatever is requested, answer on the following cycle
  task automatic tick();
    @(posedge clk); #1;
    if (auto_mem) begin
      f.imem_rvld  = f.imem_gnt;
      f.imem_rdata = insn_of(g_addr);
      f.imem_gnt   = f.imem_req;
      g_addr       = f.imem_addr;
    end
  endtask
  task automatic do_reset(input logic am);
    rst_n = 1'b0;
    auto_mem = 1'b0;
    f.imem_gnt = 0; f.imem_rvld = 0; f.imem_rdata = '0;
    f.redirect = 0; f.redirect_pc = '0; f.id_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    auto_mem = am;
    tick();
  endtask
  initial begin
    f.imem_gnt = 0; f.imem_rvld = 0; f.imem_rdata = '0;
    f.redirect = 0; f.redirect_pc = '0; f.id_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", f.imem_req, 0);
    chk("rst_addr", f.imem_addr, 32'h0);
    chk("rst_mis", f.misalign, 0);
    chk("rst_vld", f.if_vld, 0);
    chk("rst_pc", f.if_pc, 0);
    chk("rst_insn", f.if_insn, 0);
    // basic fetch, manual handshake
    do_reset(0);
    chk("t1_req0", f.imem_req, 1);
    chk("t1_addr0", f.imem_addr, 32'h0);
    f.imem_gnt = 1;
    tick();
    chk("t1_wait_req", f.imem_req, 0);
    f.imem_gnt = 0; f.imem_rvld = 1; f.imem_rdata = 32'h0050_0093;
    tick();
    chk("t1_vld", f.if_vld, 1);
    chk("t1_pc", f.if_pc, 32'h0);
    chk("t1_insn", f.if_insn, 32'h0050_0093);
    chk("t1_addr4", f.imem_addr, 32'h4);
    f.imem_rvld = 0; f.imem_gnt = 1;
    tick();
    chk("t1_popped", f.if_vld, 0);
    f.imem_gnt = 0; f.imem_rvld = 1; f.imem_rdata = 32'h00A0_0113;
    tick();
    chk("t1_pc4", f.if_pc, 32'h4);
    chk("t1_insn4", f.if_insn, 32'h00A0_0113);
    chk("t1_addr8", f.imem_addr, 32'h8);
    chk("t1_req8", f.imem_req, 1);
    // backpressure fills the buffer
    do_reset(1);
    f.id_ready = 0;
    repeat (10) tick();
    chk("t2_req_full", f.imem_req, 0);
    chk("t2_vld", f.if_vld, 1);
    chk("t2_head0", f.if_pc, 32'h0);
    f.id_ready = 1;
    tick();
    chk("t2_head4", f.if_pc, 32'h4);
    chk("t2_insn4", f.if_insn, 32'h1300_0004);
    chk("t2_req8", f.imem_req, 1);
    chk("t2_addr8", f.imem_addr, 32'h8);
    tick();
    chk("t2_empty", f.if_vld, 0);
    // redirect while waiting, late response discarded
    do_reset(0);
    f.imem_gnt = 1;
    tick();
    f.imem_gnt = 0; f.redirect = 1; f.redirect_pc = 32'h100;
    tick();
    f.redirect = 0;
    chk("t3_drain_req", f.imem_req, 0);
    chk("t3_mis", f.misalign, 0);
    tick();
    tick();
    f.imem_rvld = 1; f.imem_rdata = 32'hDEAD_BEEF;
    tick();
    f.imem_rvld = 0;
    chk("t3_vld", f.if_vld, 0);
    chk("t3_req", f.imem_req, 1);
    chk("t3_addr", f.imem_addr, 32'h100);
    tick();
    chk("t3_vld2", f.if_vld, 0);
    // redirect coincident with the grant of 0x8
    do_reset(1);
    guard = 0;
    while (!(f.imem_req && f.imem_addr == 32'h8) && guard < 20) begin tick(); guard++; end
    chk("t4_reach8", guard < 20, 1);
    f.redirect = 1; f.redirect_pc = 32'h100;
    tick();
    f.redirect = 0;
    guard = 0;
    while (!f.if_vld && guard < 20) begin tick(); guard++; end
    chk("t4_vld", f.if_vld, 1);
    chk("t4_pc", f.if_pc, 32'h100);
    chk("t4_insn", f.if_insn, 32'h1300_0100);
    // misaligned target, then wrap from the top of the address space
    do_reset(0);
    f.redirect = 1; f.redirect_pc = 32'h102;
    tick();
    f.redirect = 0;
    chk("t5_mis1", f.misalign, 1);
    chk("t5_addr", f.imem_addr, 32'h100);
    chk("t5_req", f.imem_req, 1);
    tick();
    chk("t5_mis0", f.misalign, 0);
    f.redirect = 1; f.redirect_pc = 32'hFFFF_FFFC;
    tick();
    f.redirect = 0;
    chk("t5_addr_top", f.imem_addr, 32'hFFFF_FFFC);
    chk("t5_mis_top", f.misalign, 0);
    f.imem_gnt = 1;
    tick();
    f.imem_gnt = 0; f.imem_rvld = 1; f.imem_rdata = 32'h1234_5678;
    tick();
    f.imem_rvld = 0;
    chk("t5_wrap", f.imem_addr, 32'h0);
    chk("t5_top_pc", f.if_pc, 32'hFFFF_FFFC);
    // asynchronous reset in the middle of a fetch
    do_reset(0);
    f.id_ready = 0;
    f.imem_gnt = 1;
    tick();
    f.imem_gnt = 0; f.imem_rvld = 1; f.imem_rdata = 32'h0000_0013;
    tick();
    f.imem_rvld = 0; f.imem_gnt = 1;
    tick();
    f.imem_gnt = 0;
    chk("t6_pre_vld", f.if_vld, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_req", f.imem_req, 0);
    chk("t6_addr", f.imem_addr, 32'h0);
    chk("t6_mis", f.misalign, 0);
    chk("t6_vld", f.if_vld, 0);
    chk("t6_pc", f.if_pc, 32'h0);
    chk("t6_insn", f.if_insn, 32'h0);
    f.imem_rvld = 1; f.imem_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
    f.imem_rvld = 0;
    chk("t6_idle_rvld", f.if_vld, 0);
    chk("t6_req_after", f.imem_req, 1);
    chk("t6_addr_after", f.imem_addr, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
